i2s_tx_24: RTL and testbench

I2S master transmitter, the sending counterpart to the 24-bit I2S capture block. It divides the system clock to generate `sck_o` and `ws_o`, and shifts out stereo 24-bit samples MSB-first on `sd_o` in standard I2S framing. Samples enter through a one-entry valid/ready buffer. The block drives DAC/codec inputs and sim loopback into the capture block.

---
 rtl/i2s_tx_24.sv | 151 +++++++++++++++
 tb/tb_i2s_tx_24.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_24.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2s_tx_24 : I2S master transmitter, stereo 24-bit, one-entry input buffer |
// | Optional macro I2S_TX_REPEAT_EN: retransmit the last pair on underrun.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module i2s_tx_24 #(
  parameter int CLK_DIV   = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] left_i,
  input  logic [23:0] right_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        sck_o,
  output logic        ws_o,
  output logic        sd_o,
  output logic        underrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_BITS);

  localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] C_POS_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_POS_LAST   = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] C_POS_SLOT   = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] C_POS_WS_ON  = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] C_POS_WS_OFF = CNT_W'(2 * SLOT_BITS - 2);
  localparam logic [CNT_W-1:0] C_DATA_BITS  = CNT_W'(24);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic             ws_q, ws_d;
  logic             sd_q, sd_d;
  logic [47:0]      shift_q, shift_d;
  logic             und_q, und_d;
  logic             ready_q, ready_d;
  logic [47:0]      buf_q, buf_d;

  logic             w_tick;
  logic             w_fall;
  logic             w_load;
  logic             w_accept;
  logic [CNT_W-1:0] w_pos_nxt;
  logic [CNT_W-1:0] w_slot_k;
  logic [47:0]      w_idle_src;
  logic [47:0]      w_frame_src;

`ifdef I2S_TX_REPEAT_EN
  logic [47:0] prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= '0;
    end else if (w_load && !ready_q) begin
      prev_q <= buf_q;
    end
  end

  assign w_idle_src = prev_q;
`else
  assign w_idle_src = '0;
`endif

  always_comb begin
    div_d       = div_q + C_DIV_ONE;
    sck_d       = sck_q;
    pos_d       = pos_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    shift_d     = shift_q;
    und_d       = 1'b0;
    ready_d     = ready_q;
    buf_d       = buf_q;

    w_tick      = (div_q == C_DIV_LAST);
    w_fall      = w_tick && sck_q;
    w_pos_nxt   = (pos_q == C_POS_LAST) ? '0 : pos_q + C_POS_ONE;
    w_slot_k    = (w_pos_nxt >= C_POS_SLOT) ? w_pos_nxt - C_POS_SLOT : w_pos_nxt;
    w_load      = w_fall && (w_pos_nxt == '0);
    w_accept    = valid_i && ready_q;
    w_frame_src = ready_q ? w_idle_src : buf_q;

    if (w_tick) begin
      div_d = '0;
      sck_d = ~sck_q;
    end

    // After 23 shifts the right sample sits at the top, ready for its slot.
    if (w_fall) begin
      pos_d = w_pos_nxt;
      ws_d  = (w_pos_nxt >= C_POS_WS_ON) && (w_pos_nxt <= C_POS_WS_OFF);
      if (w_load) begin
        sd_d    = w_frame_src[47];
        shift_d = {w_frame_src[46:0], 1'b0};
        und_d   = ready_q;
      end else if (w_slot_k < C_DATA_BITS) begin
        sd_d    = shift_q[47];
        shift_d = {shift_q[46:0], 1'b0};
      end else begin
        sd_d    = 1'b0;
      end
    end

    // Load sees the pre-cycle buffer; accept and buffer-load are exclusive.
    if (w_load && !ready_q) begin
      ready_d = 1'b1;
    end
    if (w_accept) begin
      ready_d = 1'b0;
      buf_d   = {left_i, right_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      sck_q   <= 1'b0;
      pos_q   <= C_POS_LAST;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      shift_q <= '0;
      und_q   <= 1'b0;
      ready_q <= 1'b1;
      buf_q   <= '0;
    end else begin
      div_q   <= div_d;
      sck_q   <= sck_d;
      pos_q   <= pos_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      shift_q <= shift_d;
      und_q   <= und_d;
      ready_q <= ready_d;
      buf_q   <= buf_d;
    end
  end

  assign ready_o    = ready_q;
  assign sck_o      = sck_q;
  assign ws_o       = ws_q;
  assign sd_o       = sd_q;
  assign underrun_o = und_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_24.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2s_tx_24 : scoreboard bench, serial frames rebuilt from sck/ws/sd     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_i2s_tx_24;

  localparam int CLK_DIV   = 2;
  localparam int SLOT_BITS = 32;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        valid = 1'b0;
  logic [23:0] left  = '0;
  logic [23:0] right = '0;
  logic        ready, sck, ws, sd, und;

  always #5 clk = ~clk;

  i2s_tx_24 #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .left_i    (left),
    .right_i   (right),
    .valid_i   (valid),
    .ready_o   (ready),
    .sck_o     (sck),
    .ws_o      (ws),
    .sd_o      (sd),
    .underrun_o(und)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        und;
    int          rdy;   // ready_o high cycles in the frame window, -1 = any
  } frame_t;

  frame_t exp_q[$];
  int n_checks    = 0;
  int n_pass      = 0;
  int ecount      = 0;
  int frames_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic expect_frame(input logic [23:0] l, input logic [23:0] r,
                              input logic u, input int rdy);
    frame_t f;
    f.l = l; f.r = r; f.und = u; f.rdy = rdy;
    exp_q.push_back(f);
  endtask

  always @(posedge clk) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  // Receiver: samples on sck rising edges; rise n after reset is position n-1.
  logic [63:0] rx_sd, rx_ws;
  int rx_pos   = 63;
  bit rx_live  = 1'b0;
  bit prev_sck = 1'b0;
  bit und_seen = 1'b0;
  int rdy_cnt  = 0;

  task automatic check_frame();
    frame_t      e;
    logic [23:0] gl, gr;
    logic [15:0] pad;
    logic [63:0] ws_exp;
    for (int i = 0; i < 24; i++) begin
      gl[23-i] = rx_sd[i];
      gr[23-i] = rx_sd[32+i];
    end
    for (int i = 0; i < 8; i++) begin
      pad[i]   = rx_sd[24+i];
      pad[8+i] = rx_sd[56+i];
    end
    ws_exp = '0;
    for (int i = 31; i < 63; i++) ws_exp[i] = 1'b1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL frame%0d_unexpected: got a frame, expected none", frames_done);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("frame%0d_left", frames_done), 64'(gl), 64'(e.l));
      check($sformatf("frame%0d_right", frames_done), 64'(gr), 64'(e.r));
      check($sformatf("frame%0d_pad", frames_done), 64'(pad), 64'd0);
      check($sformatf("frame%0d_ws", frames_done), rx_ws, ws_exp);
      check($sformatf("frame%0d_underrun", frames_done), 64'(und_seen), 64'(e.und));
      if (e.rdy >= 0)
        check($sformatf("frame%0d_ready_cycles", frames_done), 64'(rdy_cnt), 64'(e.rdy));
    end
    frames_done++;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rx_pos   = 63;
      rx_live  = 1'b0;
      prev_sck = 1'b0;
      und_seen = 1'b0;
      rdy_cnt  = 0;
    end else begin
      if (und)   und_seen = 1'b1;
      if (ready) rdy_cnt++;
      if (sck && !prev_sck) begin
        rx_sd[rx_pos] = sd;
        rx_ws[rx_pos] = ws;
        if (rx_pos == 63) begin
          if (rx_live) check_frame();
          rx_live  = 1'b1;
          und_seen = 1'b0;
          rdy_cnt  = 0;
        end
        rx_pos = (rx_pos + 1) % 64;
      end
      prev_sck = sck;
    end
  end

  task automatic wait_edge(input int n);
    while (ecount < n) @(negedge clk);
  endtask

  // Leaves valid high; returns at the negedge after the accepting edge.
  task automatic send(input logic [23:0] l, input logic [23:0] r);
    int t = 0;
    valid = 1'b1; left = l; right = r;
    while (!ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_checks++;
      $display("FAIL send_timeout: ready_o still 0, expected 1 within 2000 cycles");
    end
    @(negedge clk);
  endtask

  logic [23:0] idle_l, idle_r;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_sck", 64'(sck), 64'd0);
    check("reset_ws", 64'(ws), 64'd0);
    check("reset_sd", 64'(sd), 64'd0);
    check("reset_underrun", 64'(und), 64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    expect_frame(24'h0, 24'h0, 1'b1, -1);

    wait_edge(1); check("sck_e1", 64'(sck), 64'd0);
    wait_edge(2); check("sck_rise_e2", 64'(sck), 64'd1);
    wait_edge(3); check("sck_e3", 64'(sck), 64'd1);
                  check("underrun_e3", 64'(und), 64'd0);
    wait_edge(4); check("sck_fall_e4", 64'(sck), 64'd0);
                  check("underrun_e4", 64'(und), 64'd1);

    expect_frame(24'hA5A5A5, 24'h123456, 1'b0, -1);
    send(24'hA5A5A5, 24'h123456);

    expect_frame(24'h111111, 24'h0F0F01, 1'b0, 1);
    send(24'h111111, 24'h0F0F01);
    expect_frame(24'h222222, 24'h0F0F02, 1'b0, 1);
    send(24'h222222, 24'h0F0F02);
    expect_frame(24'h333333, 24'h0F0F03, 1'b0, 1);
    send(24'h333333, 24'h0F0F03);
    expect_frame(24'h444444, 24'h0F0F04, 1'b0, -1);
    send(24'h444444, 24'h0F0F04);

    expect_frame(24'h7FFFFF, 24'h800000, 1'b0, -1);
    send(24'h7FFFFF, 24'h800000);
    valid = 1'b0;
`ifdef I2S_TX_REPEAT_EN
    idle_l = 24'h7FFFFF; idle_r = 24'h800000;
`else
    idle_l = 24'h0; idle_r = 24'h0;
`endif
    expect_frame(idle_l, idle_r, 1'b1, -1);
    expect_frame(idle_l, idle_r, 1'b1, -1);
    expect_frame(idle_l, idle_r, 1'b1, -1);

    // Accept exactly on the frame-9 load edge (E2308) with an empty buffer.
    wait_edge(2307);
    check("ready_empty_before_load", 64'(ready), 64'd1);
    valid = 1'b1; left = 24'hC0FFEE; right = 24'h00BEEF;
    expect_frame(24'hC0FFEE, 24'h00BEEF, 1'b0, -1);
    @(negedge clk);
    valid = 1'b0;
    check("underrun_load_cycle", 64'(und), 64'd1);
    check("ready_low_after_accept", 64'(ready), 64'd0);
    wait_edge(2563); check("ready_held_low", 64'(ready), 64'd0);
    wait_edge(2564); check("ready_after_load", 64'(ready), 64'd1);

    send(24'h654321, 24'hABCDEF);
    valid = 1'b0;
    wait_edge(2820); check("ready_after_d_load", 64'(ready), 64'd1);
    send(24'h111000, 24'h000111);
    valid = 1'b0;

    // Frame 11 is at position 40: right slot, bit 15 of 0xABCDEF.
    wait_edge(2981);
    check("buffer_full_pos40", 64'(ready), 64'd0);
    check("ws_pos40", 64'(ws), 64'd1);
    check("sd_pos40", 64'(sd), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sck", 64'(sck), 64'd0);
    check("midrst_ws", 64'(ws), 64'd0);
    check("midrst_sd", 64'(sd), 64'd0);
    check("midrst_underrun", 64'(und), 64'd0);
    check("midrst_ready", 64'(ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    expect_frame(24'h0, 24'h0, 1'b1, -1);

    wait_edge(300);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("frames_seen", 64'(frames_done), 64'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
